// File: rtl/inst_sram_resp.sv
// -----------------------------------------------------------------------------
// inst_sram_resp
//
// Memory end of the core's instruction-fetch interface. Fetch requests arrive
// on a valid/ready channel, the word array is read in the accept cycle, and the
// result travels through a fixed-length delay pipeline. It then lands in a small
// response FIFO that drives a valid/ready response channel. A credit counter
// limits the number of accepted-but-not-returned fetches to OUTSTANDING. This
// limit means the FIFO can never overflow, so its write side needs no full check.
//
// A separate loader port writes words into the array. Intended users are a
// testbench or a boot loader. The array itself is never reset.
//
// Optional feature macro: INST_SRAM_ERRCHK_EN
//   defined   : misaligned or out-of-range fetches return inst=0, err=1.
//   undefined : no checking. Address bits [DEPTH_LOG2+1:2] select the word, so
//               the array aliases across the address space. resp_err is 0.
//
// Parameters:
//   DEPTH_LOG2  - log2 of array depth in 32-bit words. Must be at most 29.
//   BASE_ADDR   - byte address of word 0.
//   LATENCY     - cycles from the accept cycle to the earliest resp_valid
//                 cycle. Legal range is 1..8.
//   OUTSTANDING - maximum number of fetches in flight. Must be a power of 2
//                 and at least 2.
//
// Ports:
//   clk, rst         - rising-edge clock, asynchronous active-high reset.
//   req_valid/ready  - fetch request handshake.
//   req_addr         - fetch byte address (the PC).
//   resp_valid/ready - response handshake.
//   resp_inst        - instruction word. Forced to 0 while no response is held.
//   resp_err         - fetch fault flag.
//   ld_en/addr/data  - loader write port, word-indexed.
// -----------------------------------------------------------------------------
module inst_sram_resp #(
  parameter int          DEPTH_LOG2  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2,
  parameter int          OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_inst,
  output logic                  resp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CREDITS = CNT_W'(OUTSTANDING);

  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  pop;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_err;

  logic                  in_valid;
  logic [31:0]           in_inst;
  logic                  in_err;

  logic                  exit_valid;
  logic [31:0]           exit_inst;
  logic                  exit_err;

  logic [31:0]           fifo_inst [OUTSTANDING];
  logic                  fifo_err  [OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      credits;

  // The handshake terms. req_ready depends only on registered credits and on
  // rst. A pop in the same cycle does not reopen the request side until the
  // next cycle.
  assign req_ready  = !rst && (credits < MAX_CREDITS);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (fifo_count != '0);
  assign pop        = resp_valid && resp_ready;

  // Address decode. With checking enabled, the word index is taken relative to
  // BASE_ADDR. Out-of-range or misaligned addresses raise err, and the index is
  // then don't-care. Without checking, the index comes straight from the PC
  // bits and every other address bit is ignored.
`ifdef INST_SRAM_ERRCHK_EN
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);

  logic [31:0] offset;
  logic        unused_offset_bits;

  assign offset             = req_addr - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:DEPTH_LOG2+2], offset[1:0]};

  always_comb begin
    req_err = 1'b0;
    req_idx = offset[DEPTH_LOG2+1:2];
    if ((req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
        ({1'b0, req_addr} >= END_ADDR)) begin
      req_err = 1'b1;
    end
  end
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

  always_comb begin
    req_err = 1'b0;
    req_idx = req_addr[DEPTH_LOG2+1:2];
  end
`endif

  // The loader write port. The array read below is combinational, and this
  // write lands at the edge. A fetch of the word being written in the same
  // cycle therefore sees the old contents.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Pipeline entry point: the array is read in the accept cycle. Faulting
  // fetches carry a zero word so no array contents leak out.
  always_comb begin
    in_valid = accept;
    in_inst  = '0;
    in_err   = req_err;
    if (!req_err) begin
      in_inst = mem[req_idx];
    end
  end

  // Delay pipeline. The FIFO write is itself one register stage, so only
  // LATENCY-1 extra stages sit in front of it. With LATENCY=1 the read data
  // goes straight into the FIFO at the accept edge.
  if (LATENCY == 1) begin : g_no_pipe
    assign exit_valid = in_valid;
    assign exit_inst  = in_inst;
    assign exit_err   = in_err;
  end else begin : g_pipe
    logic [LATENCY-2:0] pipe_valid;
    logic [31:0]        pipe_inst [LATENCY-1];
    logic               pipe_err  [LATENCY-1];

    // Shift register of {valid, inst, err}. Reset clears the valids so that
    // nothing in flight survives a reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_valid <= '0;
        for (int i = 0; i < LATENCY - 1; i++) begin
          pipe_inst[i] <= '0;
          pipe_err[i]  <= 1'b0;
        end
      end else begin
        pipe_valid[0] <= in_valid;
        pipe_inst[0]  <= in_inst;
        pipe_err[0]   <= in_err;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pipe_valid[i] <= pipe_valid[i-1];
          pipe_inst[i]  <= pipe_inst[i-1];
          pipe_err[i]   <= pipe_err[i-1];
        end
      end
    end

    assign exit_valid = pipe_valid[LATENCY-2];
    assign exit_inst  = pipe_inst[LATENCY-2];
    assign exit_err   = pipe_err[LATENCY-2];
  end

  // FIFO storage. The credit limit guarantees a free slot whenever the
  // pipeline exits, so the write is unconditional on fullness. Storage is not
  // reset, because the outputs are masked by resp_valid.
  always_ff @(posedge clk) begin
    if (exit_valid) begin
      fifo_inst[wr_ptr] <= exit_inst;
      fifo_err[wr_ptr]  <= exit_err;
    end
  end

  // FIFO pointers and occupancy. OUTSTANDING is a power of two, so the
  // pointers wrap naturally at their width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (exit_valid) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({exit_valid, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Credits count every fetch from accept until its response is popped. This
  // covers both pipeline and FIFO occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits + CNT_W'(1);
        2'b01:   credits <= credits - CNT_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Response outputs present the FIFO head. The head cannot change until it is
  // popped, so the outputs stay stable under back-pressure.
  always_comb begin
    resp_inst = '0;
    resp_err  = 1'b0;
    if (resp_valid) begin
      resp_inst = fifo_inst[rd_ptr];
      resp_err  = fifo_err[rd_ptr];
    end
  end

endmodule

// File: tb/tb_inst_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_inst_sram_resp
//
// Directed testbench for inst_sram_resp with default parameters
// (LATENCY=2, OUTSTANDING=4). Inputs are driven, and outputs are sampled, 1 time
// unit after each rising edge. The fault-handling expectations follow whether
// INST_SRAM_ERRCHK_EN is defined.
// -----------------------------------------------------------------------------
module tb_inst_sram_resp;

  localparam int          DEPTH_LOG2  = 12;
  localparam logic [31:0] BASE_ADDR   = 32'h8000_0000;
  localparam int          LATENCY     = 2;
  localparam int          OUTSTANDING = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_inst;
  logic                  resp_err;
  logic                  ld_en;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [31:0]           ld_data;

  int n_compared = 0;
  int n_failed   = 0;

  logic [31:0] stim_addr [16];
  int          stim_n;
  logic [31:0] cap_inst  [16];
  logic        cap_err   [16];
  int          cap_cycle [16];
  int          cap_n;

  inst_sram_resp #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BASE_ADDR  (BASE_ADDR),
    .LATENCY    (LATENCY),
    .OUTSTANDING(OUTSTANDING)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_inst (resp_inst),
    .resp_err  (resp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Preloaded contents of words 0..15. Word 0 holds a recognisable addi.
  function automatic logic [31:0] exp_word(input int i);
    if (i == 0) return 32'h0000_0413;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues stim_addr[0..stim_n-1], one per cycle, whenever the block is ready.
  // Every response is accepted immediately. Each response is recorded with the
  // loop cycle in which it was visible. Cycle 0 is the cycle the first request
  // is driven.
  task automatic applyStimulus(input int budget);
    int sent;
    sent       = 0;
    cap_n      = 0;
    resp_ready = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (sent < stim_n) begin
        req_valid = 1'b1;
        req_addr  = stim_addr[sent];
      end else begin
        req_valid = 1'b0;
        req_addr  = '0;
      end
      if (resp_valid && cap_n < 16) begin
        cap_inst[cap_n]  = resp_inst;
        cap_err[cap_n]   = resp_err;
        cap_cycle[cap_n] = cyc;
        cap_n++;
      end
      if (req_valid && req_ready) sent++;
      tick();
    end
    req_valid = 1'b0;
    req_addr  = '0;
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      ld_en   = 1'b1;
      ld_addr = DEPTH_LOG2'(i);
      ld_data = exp_word(i);
      tick();
    end
    ld_en = 1'b0;
  endtask

  // Reset held for three cycles with a request pending. Nothing may be
  // accepted, and nothing may emerge afterwards.
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_compared++;
      if (req_ready !== 1'b0) begin
        n_failed++;
        $display("[TB] FAIL reset_req_ready c%0d: got %b expected 0", i, req_ready);
      end
      n_compared++;
      if (resp_valid !== 1'b0 || resp_inst !== 32'h0 || resp_err !== 1'b0) begin
        n_failed++;
        $display("[TB] FAIL reset_resp c%0d: got v=%b i=%h e=%b expected 0/0/0",
                 i, resp_valid, resp_inst, resp_err);
      end
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    n_compared++;
    if (req_ready !== 1'b1) begin
      n_failed++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_compared++;
      if (resp_valid !== 1'b0) begin
        n_failed++;
        $display("[TB] FAIL reset_no_resp c%0d: got %b expected 0", i, resp_valid);
      end
    end
  endtask

  // A single fetch of word 0. resp_valid must rise exactly LATENCY cycles
  // after the accept cycle.
  task automatic test_single();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0000;
    n_compared++;
    if (req_ready !== 1'b1) begin
      n_failed++;
      $display("[TB] FAIL single_ready: got %b expected 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    n_compared++;
    if (resp_valid !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL single_early: got %b expected 0", resp_valid);
    end
    tick();
    n_compared++;
    if (resp_valid !== 1'b1 || resp_inst !== 32'h0000_0413 || resp_err !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL single_resp: got v=%b i=%h e=%b expected 1/00000413/0",
               resp_valid, resp_inst, resp_err);
    end
    tick();
    n_compared++;
    if (resp_valid !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL single_once: got %b expected 0", resp_valid);
    end
  endtask

  // Eight back-to-back fetches. Response k must be visible in cycle k+2.
  task automatic test_stream();
    for (int i = 0; i < 8; i++) stim_addr[i] = 32'h8000_0000 + 32'(4 * i);
    stim_n = 8;
    applyStimulus(12);
    n_compared++;
    if (cap_n !== 8) begin
      n_failed++;
      $display("[TB] FAIL stream_count: got %0d expected 8", cap_n);
    end
    for (int k = 0; k < 8 && k < cap_n; k++) begin
      n_compared++;
      if (cap_inst[k] !== exp_word(k) || cap_err[k] !== 1'b0) begin
        n_failed++;
        $display("[TB] FAIL stream_data%0d: got %h/%b expected %h/0",
                 k, cap_inst[k], cap_err[k], exp_word(k));
      end
      n_compared++;
      if (cap_cycle[k] !== k + LATENCY) begin
        n_failed++;
        $display("[TB] FAIL stream_cycle%0d: got %0d expected %0d",
                 k, cap_cycle[k], k + LATENCY);
      end
    end
  endtask

  // Six requests for words 8..13 while the response side is stalled. Only four
  // may be accepted. Draining must return all six, in order.
  task automatic test_back_pressure();
    int p;
    int k;
    p          = 0;
    k          = 0;
    resp_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      req_valid = (p < 6);
      req_addr  = 32'h8000_0020 + 32'(4 * p);
      if (req_valid && req_ready) p++;
      tick();
    end
    n_compared++;
    if (p !== 4) begin
      n_failed++;
      $display("[TB] FAIL bp_accepted: got %0d expected 4", p);
    end
    n_compared++;
    if (req_ready !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL bp_full_ready: got %b expected 0", req_ready);
    end
    n_compared++;
    if (resp_valid !== 1'b1 || resp_inst !== exp_word(8)) begin
      n_failed++;
      $display("[TB] FAIL bp_head: got %b/%h expected 1/%h", resp_valid, resp_inst, exp_word(8));
    end
    resp_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      req_valid = (p < 6);
      req_addr  = 32'h8000_0020 + 32'(4 * p);
      if (cyc == 0) begin
        n_compared++;
        if (req_ready !== 1'b0) begin
          n_failed++;
          $display("[TB] FAIL bp_pop_same_cycle: got %b expected 0", req_ready);
        end
      end
      if (cyc == 1) begin
        n_compared++;
        if (req_ready !== 1'b1) begin
          n_failed++;
          $display("[TB] FAIL bp_pop_next_cycle: got %b expected 1", req_ready);
        end
      end
      if (resp_valid) begin
        n_compared++;
        if (k >= 6) begin
          n_failed++;
          $display("[TB] FAIL bp_extra: got response %h expected none", resp_inst);
        end else if (resp_inst !== exp_word(8 + k) || resp_err !== 1'b0) begin
          n_failed++;
          $display("[TB] FAIL bp_data%0d: got %h/%b expected %h/0",
                   k, resp_inst, resp_err, exp_word(8 + k));
        end
        k++;
      end
      if (req_valid && req_ready) p++;
      tick();
    end
    req_valid = 1'b0;
    n_compared++;
    if (k !== 6 || p !== 6) begin
      n_failed++;
      $display("[TB] FAIL bp_totals: got %0d returned/%0d accepted expected 6/6", k, p);
    end
  endtask

  // Fault handling. Word 4095 is loaded so that both the last legal word and
  // the aliased accesses have a known value.
  task automatic test_faults();
    logic [31:0] exp_inst [4];
    logic        exp_err  [4];
    ld_en   = 1'b1;
    ld_addr = 12'hFFF;
    ld_data = 32'hCAFE_F00D;
    tick();
    ld_en = 1'b0;
    stim_addr[0] = 32'h8000_0002;
    stim_addr[1] = 32'h8000_4000;
    stim_addr[2] = 32'h7FFF_FFFC;
    stim_addr[3] = 32'h8000_3FFC;
    stim_n       = 4;
`ifdef INST_SRAM_ERRCHK_EN
    exp_inst[0] = 32'h0;          exp_err[0] = 1'b1;
    exp_inst[1] = 32'h0;          exp_err[1] = 1'b1;
    exp_inst[2] = 32'h0;          exp_err[2] = 1'b1;
    exp_inst[3] = 32'hCAFE_F00D;  exp_err[3] = 1'b0;
`else
    exp_inst[0] = 32'h0000_0413;  exp_err[0] = 1'b0;
    exp_inst[1] = 32'h0000_0413;  exp_err[1] = 1'b0;
    exp_inst[2] = 32'hCAFE_F00D;  exp_err[2] = 1'b0;
    exp_inst[3] = 32'hCAFE_F00D;  exp_err[3] = 1'b0;
`endif
    applyStimulus(10);
    n_compared++;
    if (cap_n !== 4) begin
      n_failed++;
      $display("[TB] FAIL fault_count: got %0d expected 4", cap_n);
    end
    for (int k = 0; k < 4 && k < cap_n; k++) begin
      n_compared++;
      if (cap_inst[k] !== exp_inst[k] || cap_err[k] !== exp_err[k]) begin
        n_failed++;
        $display("[TB] FAIL fault_resp%0d: got %h/%b expected %h/%b",
                 k, cap_inst[k], cap_err[k], exp_inst[k], exp_err[k]);
      end
    end
  endtask

  // A loader write to word 1 in the same cycle as a fetch of word 1. That fetch
  // sees the old word, and the following fetch sees the new one.
  task automatic test_hazard();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0004;
    ld_en      = 1'b1;
    ld_addr    = 12'd1;
    ld_data    = 32'hDEAD_BEEF;
    tick();
    ld_en = 1'b0;
    tick();
    req_valid = 1'b0;
    n_compared++;
    if (resp_valid !== 1'b1 || resp_inst !== exp_word(1)) begin
      n_failed++;
      $display("[TB] FAIL hazard_old: got %b/%h expected 1/%h", resp_valid, resp_inst, exp_word(1));
    end
    tick();
    n_compared++;
    if (resp_valid !== 1'b1 || resp_inst !== 32'hDEAD_BEEF) begin
      n_failed++;
      $display("[TB] FAIL hazard_new: got %b/%h expected 1/deadbeef", resp_valid, resp_inst);
    end
    tick();
    n_compared++;
    if (resp_valid !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL hazard_drain: got %b expected 0", resp_valid);
    end
  endtask

  // Reset with three fetches buffered. They must vanish. Credits must restart
  // at 0, so exactly four new fetches fit before req_ready drops.
  task automatic test_reset_midop();
    int p;
    int k;
    int stale;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h8000_0008 + 32'(4 * i);
      tick();
    end
    req_valid = 1'b0;
    tick();
    tick();
    n_compared++;
    if (resp_valid !== 1'b1) begin
      n_failed++;
      $display("[TB] FAIL midrst_pending: got %b expected 1", resp_valid);
    end
    rst = 1'b1;
    #1;
    n_compared++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0 || resp_inst !== 32'h0) begin
      n_failed++;
      $display("[TB] FAIL midrst_outputs: got v=%b r=%b i=%h expected 0/0/0",
               resp_valid, req_ready, resp_inst);
    end
    tick();
    tick();
    rst        = 1'b0;
    resp_ready = 1'b1;
    #1;
    n_compared++;
    if (req_ready !== 1'b1) begin
      n_failed++;
      $display("[TB] FAIL midrst_ready: got %b expected 1", req_ready);
    end
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) stale++;
      tick();
    end
    n_compared++;
    if (stale !== 0) begin
      n_failed++;
      $display("[TB] FAIL midrst_stale: got %0d responses expected 0", stale);
    end
    p          = 0;
    resp_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      req_valid = 1'b1;
      req_addr  = 32'h8000_0014 + 32'(4 * p);
      if (req_ready) p++;
      tick();
    end
    req_valid = 1'b0;
    n_compared++;
    if (p !== 4) begin
      n_failed++;
      $display("[TB] FAIL midrst_credits: got %0d accepted expected 4", p);
    end
    k          = 0;
    resp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (resp_valid) begin
        n_compared++;
        if (k >= 4 || resp_inst !== exp_word(5 + k)) begin
          n_failed++;
          $display("[TB] FAIL midrst_data%0d: got %h expected %h", k, resp_inst, exp_word(5 + k));
        end
        k++;
      end
      tick();
    end
    n_compared++;
    if (k !== 4) begin
      n_failed++;
      $display("[TB] FAIL midrst_returned: got %0d expected 4", k);
    end
  endtask

  // The test sequence runs from power-up with reset asserted.
  initial begin
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0000;
    resp_ready = 1'b0;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    test_reset();
    preload();
    test_single();
    test_stream();
    test_back_pressure();
    test_faults();
    test_hazard();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

  // Watchdog: guarantees termination if anything above stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
